// File: rtl/ysyx_22050133_ifu_fetch.sv
// ysyx_22050133_ifu_fetch
//   Instruction fetch stage of the RV64 pipeline. It owns the fetch PC, keeps
//   one word request outstanding to instruction memory, and fills the IF/ID
//   pipeline register that feeds decode. It honours the decode hazard stall
//   and redirects coming from branch/jump/ecall/mret resolution.
//
// Ports
//   clk            : clock, all state on the rising edge
//   rst            : asynchronous reset, active-low
//   imem_req_valid : request valid (combinational, masked by a redirect)
//   imem_req_ready : memory accepts the request
//   imem_req_addr  : fetch address, always the fetch PC
//   imem_rsp_valid : response valid, one per accepted request
//   imem_rsp_data  : instruction word
//   id_stall       : decode hazard, hold IF/ID
//   redirect_valid : one-cycle redirect pulse
//   redirect_pc    : redirect target (low two bits ignored)
//   id_valid       : IF/ID holds a live instruction
//   id_pc          : PC of id_inst
//   id_inst        : instruction handed to decode
module ysyx_22050133_ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        id_stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        id_valid,
  output logic [63:0] id_pc,
  output logic [31:0] id_inst
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] fpc_q, fpc_d;
  logic        drop_q, drop_d;
  logic [63:0] sk_pc_q, sk_pc_d;
  logic [31:0] sk_inst_q, sk_inst_d;
  logic        id_valid_q, id_valid_d;
  logic [63:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;

  logic        dlv;
  logic [63:0] dlv_pc;
  logic [31:0] dlv_inst;
  logic [63:0] rdr_pc;

  assign rdr_pc = {redirect_pc[63:2], 2'b00};

  // A redirect masks the request in the same cycle so a stale address is
  // never handed to memory.
  assign imem_req_valid = (state_q == S_REQ) && !redirect_valid;
  assign imem_req_addr  = fpc_q;

  assign id_valid = id_valid_q;
  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;

  always_comb begin
    state_d   = state_q;
    fpc_d     = fpc_q;
    drop_d    = drop_q;
    sk_pc_d   = sk_pc_q;
    sk_inst_d = sk_inst_q;
    dlv       = 1'b0;
    dlv_pc    = fpc_q;
    dlv_inst  = imem_rsp_data;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (redirect_valid) begin
          fpc_d = rdr_pc;
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (drop_q || redirect_valid) begin
            // Word belongs to a flushed path. A redirect arriving now has
            // not been requested yet, so it is simply refetched from REQ.
            drop_d  = 1'b0;
            state_d = S_REQ;
            if (redirect_valid) fpc_d = rdr_pc;
          end else if (id_stall) begin
            sk_pc_d   = fpc_q;
            sk_inst_d = imem_rsp_data;
            state_d   = S_HOLD;
          end else begin
            dlv     = 1'b1;
            fpc_d   = fpc_q + 64'd4;
            state_d = S_REQ;
          end
        end else if (redirect_valid) begin
          // The outstanding response must still be absorbed before the
          // new target can be requested.
          fpc_d  = rdr_pc;
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          fpc_d   = rdr_pc;
          state_d = S_REQ;
        end else if (!id_stall) begin
          dlv      = 1'b1;
          dlv_pc   = sk_pc_q;
          dlv_inst = sk_inst_q;
          fpc_d    = fpc_q + 64'd4;
          state_d  = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // IF/ID: redirect flushes (even under stall), stall holds, otherwise the
  // slot takes the delivered word or empties to a NOP bubble.
  always_comb begin
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    if (redirect_valid) begin
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
    end else if (!id_stall) begin
      if (dlv) begin
        id_valid_d = 1'b1;
        id_pc_d    = dlv_pc;
        id_inst_d  = dlv_inst;
      end else begin
        id_valid_d = 1'b0;
        id_inst_d  = NOP_INST;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fpc_q      <= RESET_PC;
      drop_q     <= 1'b0;
      id_valid_q <= 1'b0;
      id_pc_q    <= 64'd0;
      id_inst_q  <= NOP_INST;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      drop_q     <= drop_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
    end
  end

  // Skid contents are only read in HOLD, which is always entered by a write.
  always_ff @(posedge clk) begin
    sk_pc_q   <= sk_pc_d;
    sk_inst_q <= sk_inst_d;
  end

endmodule

// File: tb/tb_ysyx_22050133_ifu_fetch.sv
module tb_ysyx_22050133_ifu_fetch;

  localparam logic [63:0] B = 64'h0000_0000_8000_0000;
  localparam logic [31:0] N = 32'h0000_0013;
  localparam logic [31:0] A0 = 32'h0010_0093;
  localparam logic [31:0] A1 = 32'h0020_0113;
  localparam logic [31:0] A2 = 32'h0030_0193;
  localparam logic [31:0] A3 = 32'h0040_0213;
  localparam logic [31:0] A4 = 32'h0050_0293;
  localparam logic [31:0] A5 = 32'h0060_0313;
  localparam logic [31:0] A6 = 32'h0070_0393;
  localparam logic [31:0] A7 = 32'h0080_0413;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_inst;

  int total = 0;
  int bad   = 0;

  ysyx_22050133_ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_stall       (id_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_inst        (id_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        rspv;
    logic [31:0] rspd;
    logic        stall;
    logic        rdrv;
    logic [63:0] rdrpc;
    logic        erv;
    logic [63:0] eaddr;
    logic        eidv;
    logic [63:0] eidpc;
    logic [31:0] eidinst;
  } vec_t;

  vec_t vecs [31];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, check the combinational request just
  // after, then check IF/ID just after the rising edge.
  task automatic step(input vec_t v, input int idx);
    @(negedge clk);
    imem_req_ready = v.rdy;
    imem_rsp_valid = v.rspv;
    imem_rsp_data  = v.rspd;
    id_stall       = v.stall;
    redirect_valid = v.rdrv;
    redirect_pc    = v.rdrpc;
    #1;
    chk($sformatf("v%0d req_valid", idx), {63'd0, imem_req_valid}, {63'd0, v.erv});
    chk($sformatf("v%0d req_addr", idx), imem_req_addr, v.eaddr);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d id_valid", idx), {63'd0, id_valid}, {63'd0, v.eidv});
    chk($sformatf("v%0d id_pc", idx), id_pc, v.eidpc);
    chk($sformatf("v%0d id_inst", idx), {32'd0, id_inst}, {32'd0, v.eidinst});
  endtask

  vec_t h;

  initial begin
    //           rdy   rspv  rspd           stl   rdrv  rdrpc          erv   eaddr          eidv  eidpc          eidinst
    vecs[0]  = '{1'b1, 1'b0, 32'd0,         1'b0, 1'b0, 64'd0,         1'b0, B,             1'b0, 64'd0,         N };
    vecs[1]  = '{1'b1, 1'b0, 32'd0,         1'b0, 1'b0, 64'd0,         1'b1, B,             1'b0, 64'd0,         N };
    vecs[2]  = '{1'b1, 1'b1, A0,            1'b0, 1'b0, 64'd0,         1'b0, B,             1'b1, B,             A0};
    vecs[3]  = '{1'b1, 1'b0, 32'd0,         1'b0, 1'b0, 64'd0,         1'b1, B+64'h4,       1'b0, B,             N };
    vecs[4]  = '{1'b1, 1'b1, A1,            1'b0, 1'b0, 64'd0,         1'b0, B+64'h4,       1'b1, B+64'h4,       A1};
    vecs[5]  = '{1'b1, 1'b0, 32'd0,         1'b1, 1'b0, 64'd0,         1'b1, B+64'h8,       1'b1, B+64'h4,       A1};
    vecs[6]  = '{1'b1, 1'b1, A2,            1'b1, 1'b0, 64'd0,         1'b0, B+64'h8,       1'b1, B+64'h4,       A1};
    vecs[7]  = '{1'b1, 1'b0, 32'd0,         1'b1, 1'b0, 64'd0,         1'b0, B+64'h8,       1'b1, B+64'h4,       A1};
    vecs[8]  = '{1'b1, 1'b0, 32'd0,         1'b0, 1'b0, 64'd0,         1'b0, B+64'h8,       1'b1, B+64'h8,       A2};
    vecs[9]  = '{1'b0, 1'b0, 32'd0,         1'b0, 1'b0, 64'd0,         1'b1, B+64'hC,       1'b0, B+64'h8,       N };
    vecs[10] = '{1'b0, 1'b0, 32'd0,         1'b0, 1'b0, 64'd0,         1'b1, B+64'hC,       1'b0, B+64'h8,       N };
    vecs[11] = '{1'b1, 1'b0, 32'd0,         1'b0, 1'b0, 64'd0,         1'b1, B+64'hC,       1'b0, B+64'h8,       N };
    vecs[12] = '{1'b1, 1'b0, 32'd0,         1'b0, 1'b1, B+64'h1000,    1'b0, B+64'hC,       1'b0, B+64'h8,       N };
    vecs[13] = '{1'b1, 1'b0, 32'd0,         1'b0, 1'b0, 64'd0,         1'b0, B+64'h1000,    1'b0, B+64'h8,       N };
    vecs[14] = '{1'b1, 1'b0, 32'd0,         1'b0, 1'b0, 64'd0,         1'b0, B+64'h1000,    1'b0, B+64'h8,       N };
    vecs[15] = '{1'b1, 1'b1, 32'hDEADBEEF,  1'b0, 1'b0, 64'd0,         1'b0, B+64'h1000,    1'b0, B+64'h8,       N };
    vecs[16] = '{1'b1, 1'b0, 32'd0,         1'b0, 1'b0, 64'd0,         1'b1, B+64'h1000,    1'b0, B+64'h8,       N };
    vecs[17] = '{1'b1, 1'b1, A3,            1'b0, 1'b0, 64'd0,         1'b0, B+64'h1000,    1'b1, B+64'h1000,    A3};
    vecs[18] = '{1'b1, 1'b0, 32'd0,         1'b0, 1'b0, 64'd0,         1'b1, B+64'h1004,    1'b0, B+64'h1000,    N };
    vecs[19] = '{1'b1, 1'b1, 32'h11111111,  1'b0, 1'b1, B+64'h203,     1'b0, B+64'h1004,    1'b0, B+64'h1000,    N };
    vecs[20] = '{1'b1, 1'b0, 32'd0,         1'b0, 1'b0, 64'd0,         1'b1, B+64'h200,     1'b0, B+64'h1000,    N };
    vecs[21] = '{1'b1, 1'b1, A4,            1'b0, 1'b0, 64'd0,         1'b0, B+64'h200,     1'b1, B+64'h200,     A4};
    vecs[22] = '{1'b1, 1'b0, 32'd0,         1'b1, 1'b1, B+64'h400,     1'b0, B+64'h204,     1'b0, B+64'h200,     N };
    vecs[23] = '{1'b1, 1'b0, 32'd0,         1'b0, 1'b0, 64'd0,         1'b1, B+64'h400,     1'b0, B+64'h200,     N };
    vecs[24] = '{1'b1, 1'b0, 32'd0,         1'b0, 1'b0, 64'd0,         1'b0, B+64'h400,     1'b0, B+64'h200,     N };
    vecs[25] = '{1'b1, 1'b1, A5,            1'b1, 1'b0, 64'd0,         1'b0, B+64'h400,     1'b0, B+64'h200,     N };
    vecs[26] = '{1'b1, 1'b0, 32'd0,         1'b1, 1'b1, B+64'h800,     1'b0, B+64'h400,     1'b0, B+64'h200,     N };
    vecs[27] = '{1'b0, 1'b1, 32'h22222222,  1'b0, 1'b0, 64'd0,         1'b1, B+64'h800,     1'b0, B+64'h200,     N };
    vecs[28] = '{1'b1, 1'b0, 32'd0,         1'b0, 1'b0, 64'd0,         1'b1, B+64'h800,     1'b0, B+64'h200,     N };
    vecs[29] = '{1'b1, 1'b1, A6,            1'b0, 1'b0, 64'd0,         1'b0, B+64'h800,     1'b1, B+64'h800,     A6};
    vecs[30] = '{1'b0, 1'b0, 32'd0,         1'b0, 1'b0, 64'd0,         1'b1, B+64'h804,     1'b0, B+64'h800,     N };

    rst = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    id_stall       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("rst req_addr", imem_req_addr, B);
    chk("rst id_valid", {63'd0, id_valid}, 64'd0);
    chk("rst id_pc", id_pc, 64'd0);
    chk("rst id_inst", {32'd0, id_inst}, {32'd0, N});
    #1 rst = 1'b1;

    for (int i = 0; i < 31; i++) step(vecs[i], i);

    // Accept a request, then reset while waiting for its response.
    h = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0, 1'b1, B+64'h804, 1'b0, B+64'h800, N};
    step(h, 100);
    @(negedge clk);
    rst = 1'b0;
    imem_req_ready = 1'b0;
    #1;
    chk("arst req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("arst req_addr", imem_req_addr, B);
    chk("arst id_valid", {63'd0, id_valid}, 64'd0);
    chk("arst id_pc", id_pc, 64'd0);
    chk("arst id_inst", {32'd0, id_inst}, {32'd0, N});
    // Late response shows up while reset is held and right after release.
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h33333333;
    @(posedge clk);
    #2 rst = 1'b1;
    h = '{1'b0, 1'b1, 32'h33333333, 1'b0, 1'b0, 64'd0, 1'b0, B, 1'b0, 64'd0, N};
    step(h, 101);
    h = '{1'b0, 1'b1, 32'h33333333, 1'b0, 1'b0, 64'd0, 1'b1, B, 1'b0, 64'd0, N};
    step(h, 102);
    h = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0, 1'b1, B, 1'b0, 64'd0, N};
    step(h, 103);
    h = '{1'b1, 1'b1, A0, 1'b0, 1'b0, 64'd0, 1'b0, B, 1'b1, B, A0};
    step(h, 104);

    // Fetch PC wraps past the top of the address space.
    h = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, B+64'h4, 1'b0, B, N};
    step(h, 105);
    h = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, B, N};
    step(h, 106);
    h = '{1'b1, 1'b1, A7, 1'b0, 1'b0, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, A7};
    step(h, 107);
    h = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0, 1'b1, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, N};
    step(h, 108);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22050133_ifu_fetch.md
# ysyx_22050133_ifu_fetch

Instruction fetch stage of the ysyx_22050133 RV64 pipeline, directly upstream of the decode stage. It owns the fetch PC and issues one word request at a time to instruction memory over a valid/ready request channel and a valid-only response channel. Fetched words go into the IF/ID pipeline register, which feeds decode `pc`/`inst`. The block honours the decode-stage hazard stall and redirects from branch, jump, ecall and mret resolution.

## Interface
- `RESET_PC`, default 64'h0000_0000_8000_0000: first fetch address after reset.
- `NOP_INST`, default 32'h0000_0013: value of `id_inst` when the slot is empty (addi x0,x0,0).

- `clk`  input  1  clock; all state on rising edge.
- `rst`  input  1  reset; asynchronous, active-low (0 = reset).
- `imem_req_valid`  output  1  request valid.
- `imem_req_ready`  input  1  memory accepts request.
- `imem_req_addr`  output  64  fetch address, always equal to the fetch PC `fpc`.
- `imem_rsp_valid`  input  1  response valid; exactly one per accepted request, arriving at least 1 cycle later.
- `imem_rsp_data`  input  32  instruction word.
- `id_stall`  input  1  decode `has_hazard`; hold IF/ID.
- `redirect_valid`  input  1  one-cycle redirect pulse.
- `redirect_pc`  input  64  redirect target; bits [1:0] forced to 0.
- `id_valid`  output  1  IF/ID holds a live instruction.
- `id_pc`  output  64  PC of `id_inst`.
- `id_inst`  output  32  instruction to decode.

## Operation
- **Registers:**
  - FSM state: IDLE, REQ, WAIT, HOLD.
  - `fpc` (64 bits).
  - `drop` flag.
  - Skid buffer: `sk_pc`, `sk_inst`.
  - IF/ID register: `id_valid`, `id_pc`, `id_inst`.
- **Reset values:** state IDLE, `fpc` = RESET_PC, `drop` = 0, `id_valid` = 0, `id_pc` = 0, `id_inst` = NOP_INST, `imem_req_valid` = 0.
- **imem_req_valid** = (state == REQ) & !redirect_valid. This is combinational, so a redirect never issues a stale address.
- **IDLE:** go to REQ on the next edge unconditionally.
- **REQ:**
  - On request handshake, go to WAIT.
  - On redirect, `fpc` <= target and stay in REQ.
- **WAIT:**
  - `imem_rsp_valid` with `drop` = 1: discard the word, clear `drop`, go to REQ.
  - `imem_rsp_valid` with `drop` = 0 and no redirect:
    - If `id_stall` = 0: load IF/ID with {1, `fpc`, data}, `fpc` += 4, go to REQ.
    - If `id_stall` = 1: capture the skid buffer, go to HOLD.
  - `redirect_valid` while the response is absent: `fpc` <= target, set `drop`, stay in WAIT.
  - `redirect_valid` in the same cycle as `imem_rsp_valid`: discard the word, `fpc` <= target, go to REQ, `drop` stays 0.
- **HOLD:**
  - When `id_stall` = 0: move the skid buffer into IF/ID, `fpc` += 4, go to REQ.
  - On redirect: discard the skid buffer, `fpc` <= target, go to REQ.
- **IF/ID update priority, highest first:**
  1. `redirect_valid`: `id_valid` <= 0, `id_inst` <= NOP_INST, `id_pc` unchanged.
  2. `id_stall`: hold all three registers.
  3. Otherwise: load the new word if one is delivered this cycle; else `id_valid` <= 0, `id_inst` <= NOP_INST.
- **Redirect vs stall:** redirect overrides stall, so a flushed slot is never held.
- **PC arithmetic:** `fpc` + 4 is modulo 2^64 and wraps silently.
- **Protocol violation:** `imem_rsp_valid` in IDLE, REQ or HOLD is ignored.

## Timing
- **Best-case latency:** with `imem_req_ready` = 1 and the response one cycle after acceptance, it is 2 cycles from handshake to `id_valid`. This cycle is the response cycle, and IF/ID is loaded at its edge.
- **Throughput:** at most one instruction per 2 cycles, with one outstanding request.
- **Back-pressure:** with `imem_req_ready` low, `imem_req_valid` and `imem_req_addr` stay stable until accepted, unless a redirect occurs.
- **Async reset:** asserting `rst` mid-operation clears everything immediately. A response in flight that arrives after reset lands in IDLE or REQ and is ignored.
- **First request:** the first request is issued the second cycle after `rst` deasserts.

## Test plan
- **Reset release, zero-wait memory:** after `rst` rises, the request at 0x80000000 is issued in cycle 2. `id_valid` = 1 with `id_pc` 0x80000000 at cycle 4, and 0x80000004 at cycle 6.
- **Stall:** `id_stall` held high for 3 cycles while the response for 0x80000008 arrives. The IF/ID register holds 0x80000004 throughout. The block enters HOLD, no request is issued, and 0x80000008 appears one edge after the stall drops, with no duplicate and no loss.
- **Redirect with delayed response:** `redirect_valid` with target 0x80001000 while in WAIT, response delayed 3 cycles. The stale word is discarded. The next request goes to 0x80001000, and `id_valid` stays 0 until that word arrives.
- **Redirect coincident with response:** redirect to 0x80000200 in the same cycle as the response. The word is dropped, the next address is 0x80000200, and `drop` stays 0.
- **Redirect plus stall:** `redirect_valid` and `id_stall` high together. `id_valid` goes to 0 and `id_inst` to 0x00000013 at that edge.
- **Reset in WAIT:** `rst` pulled low while in WAIT. Outputs reset immediately. A late response is ignored, and fetch restarts at 0x80000000.
